// File: rtl/config_pkg.sv
// Peripheral map handed to the bus router: one supported/base/range triple per device.
package config_pkg;

   typedef struct packed {
      logic        BOOTROM_SUPPORTED;
      logic [31:0] BOOTROM_BASE;
      logic [31:0] BOOTROM_RANGE;
      logic        UART_SUPPORTED;
      logic [31:0] UART_BASE;
      logic [31:0] UART_RANGE;
      logic        PLIC_SUPPORTED;
      logic [31:0] PLIC_BASE;
      logic [31:0] PLIC_RANGE;
   } config_t;

endpackage

// File: rtl/periph_pkg.sv
// Shared types for the peripheral router: device indices and FSM states.
package periph_pkg;

   typedef enum {DEV_BOOTROM = 0, DEV_UART = 1, DEV_PLIC = 2} dev_e;

   localparam int NDEV = 3;

   typedef enum logic [1:0] {IDLE, DEV_REQ, DEV_WAIT, RESP} rt_state_e;

   // Inclusive window test; the offset wraps modulo 2^32.
   function automatic logic in_window(input logic        supported,
                                      input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] range);
      logic [31:0] off;
      off = addr - base;
      return supported && (addr >= base) && (off <= range);
   endfunction

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational address decoder: region hit, priority one-hot select, alignment flag.
module periph_addr_decoder
   import periph_pkg::*;
#(
   parameter config_pkg::config_t CFG = '0
) (
   input  logic [31:0]     addr_i,
   output logic            hit_o,
   output logic [NDEV-1:0] sel_o,
   output logic            misaligned_o
);

   logic [NDEV-1:0] w_region;

   // Per-device window match, then BOOTROM > UART > PLIC priority.
   always_comb begin
      w_region                 = '0;
      w_region[int'(DEV_BOOTROM)] = in_window(CFG.BOOTROM_SUPPORTED, addr_i,
                                              CFG.BOOTROM_BASE, CFG.BOOTROM_RANGE);
      w_region[int'(DEV_UART)]    = in_window(CFG.UART_SUPPORTED, addr_i,
                                              CFG.UART_BASE, CFG.UART_RANGE);
      w_region[int'(DEV_PLIC)]    = in_window(CFG.PLIC_SUPPORTED, addr_i,
                                              CFG.PLIC_BASE, CFG.PLIC_RANGE);
      sel_o = '0;
      if (w_region[int'(DEV_BOOTROM)])   sel_o[int'(DEV_BOOTROM)] = 1'b1;
      else if (w_region[int'(DEV_UART)]) sel_o[int'(DEV_UART)]    = 1'b1;
      else if (w_region[int'(DEV_PLIC)]) sel_o[int'(DEV_PLIC)]    = 1'b1;
      hit_o        = |w_region;
      misaligned_o = (addr_i[1:0] != 2'b00);
   end

endmodule

// File: rtl/periph_bus_router.sv
// Single-master router: decodes host requests, runs one device transaction, returns response.
module periph_bus_router
   import periph_pkg::*;
#(
   parameter config_pkg::config_t CFG = '0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 host_req_i,
   output logic                 host_gnt_o,
   input  logic [31:0]          host_addr_i,
   input  logic                 host_we_i,
   input  logic [3:0]           host_be_i,
   input  logic [31:0]          host_wdata_i,
   output logic                 host_rvalid_o,
   input  logic                 host_rready_i,
   output logic [31:0]          host_rdata_o,
   output logic                 host_err_o,
   output logic [NDEV-1:0]      dev_req_o,
   output logic [31:0]          dev_addr_o,
   output logic                 dev_we_o,
   output logic [3:0]           dev_be_o,
   output logic [31:0]          dev_wdata_o,
   input  logic [NDEV-1:0]      dev_gnt_i,
   input  logic [NDEV-1:0]      dev_rvalid_i,
   input  logic [NDEV-1:0][31:0] dev_rdata_i,
   input  logic [NDEV-1:0]      dev_err_i
);

   rt_state_e       r_state, w_state_next;
   logic [31:0]     r_addr, r_wdata, r_rdata, r_cnt, w_cnt_next;
   logic            r_we, r_err;
   logic [3:0]      r_be;
   logic [NDEV-1:0] r_sel, w_dec_sel;
   logic            w_dec_hit, w_misaligned, w_hit;
   logic            w_accept, w_load, w_load_err;
   logic [31:0]     w_load_rdata, w_rdata_sel;
   logic            w_gnt_sel, w_rvalid_sel, w_err_sel, w_timeout;

   periph_addr_decoder #(
      .CFG(CFG)
   ) u_decoder (
      .addr_i      (host_addr_i),
      .hit_o       (w_dec_hit),
      .sel_o       (w_dec_sel),
      .misaligned_o(w_misaligned)
   );

   assign w_hit        = w_dec_hit && !w_misaligned;
   assign w_gnt_sel    = |(dev_gnt_i & r_sel);
   assign w_rvalid_sel = |(dev_rvalid_i & r_sel);
   assign w_err_sel    = |(dev_err_i & r_sel);
   assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Read data of the selected device only; others are masked off.
   always_comb begin
      w_rdata_sel = '0;
      for (int i = 0; i < NDEV; i++) begin
         if (r_sel[i]) w_rdata_sel = w_rdata_sel | dev_rdata_i[i];
      end
   end

   // Next-state, timeout counter and response-load decisions.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_load       = 1'b0;
      w_load_err   = 1'b0;
      w_load_rdata = '0;
      unique case (r_state)
         IDLE: begin
            if (host_req_i) begin
               w_accept   = 1'b1;
               w_load     = 1'b1;
               w_load_err = !w_hit;
               if (w_hit) begin
                  w_state_next = DEV_REQ;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = RESP;
               end
            end
         end
         DEV_REQ, DEV_WAIT: begin
            if (w_rvalid_sel && (r_state == DEV_WAIT || w_gnt_sel)) begin
               w_load       = 1'b1;
               w_load_err   = w_err_sel;
               w_load_rdata = w_rdata_sel;
               w_state_next = RESP;
            end else if (w_timeout) begin
               w_load       = 1'b1;
               w_load_err   = 1'b1;
               w_state_next = RESP;
            end else begin
               w_cnt_next = r_cnt + 32'd1;
               if (r_state == DEV_REQ && w_gnt_sel) w_state_next = DEV_WAIT;
            end
         end
         RESP: begin
            if (host_rready_i) w_state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Request latches, timeout counter and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_accept) begin
            r_addr  <= host_addr_i;
            r_we    <= host_we_i;
            r_be    <= host_be_i;
            r_wdata <= host_wdata_i;
            r_sel   <= w_hit ? w_dec_sel : '0;
         end
         if (w_load) begin
            r_rdata <= w_load_rdata;
            r_err   <= w_load_err;
         end
      end
   end

   assign host_gnt_o    = (r_state == IDLE);
   assign host_rvalid_o = (r_state == RESP);
   assign host_rdata_o  = r_rdata;
   assign host_err_o    = r_err;
   assign dev_req_o     = (r_state == DEV_REQ) ? r_sel : '0;
   assign dev_addr_o    = r_addr;
   assign dev_we_o      = r_we;
   assign dev_be_o      = r_be;
   assign dev_wdata_o   = r_wdata;

endmodule

// File: tb/tb_periph_bus_router.sv
// Directed bench for periph_bus_router: routing, decode errors, timeout, back-pressure, reset.
module tb_periph_bus_router;

   localparam config_pkg::config_t CfgA = '{
      BOOTROM_SUPPORTED: 1'b1, BOOTROM_BASE: 32'h0000_1000, BOOTROM_RANGE: 32'h0000_0FFF,
      UART_SUPPORTED:    1'b1, UART_BASE:    32'h1000_0000, UART_RANGE:    32'h0000_0007,
      PLIC_SUPPORTED:    1'b1, PLIC_BASE:    32'h0C00_0000, PLIC_RANGE:    32'h03FF_FFFF};
   localparam config_pkg::config_t CfgB = '{
      BOOTROM_SUPPORTED: 1'b1, BOOTROM_BASE: 32'h0000_1000, BOOTROM_RANGE: 32'h0000_0FFF,
      UART_SUPPORTED:    1'b0, UART_BASE:    32'h1000_0000, UART_RANGE:    32'h0000_0007,
      PLIC_SUPPORTED:    1'b1, PLIC_BASE:    32'h0C00_0000, PLIC_RANGE:    32'h03FF_FFFF};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req = 1'b0, req_b = 1'b0, we = 1'b0, rready = 1'b1;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] be = 4'hF;
   logic [2:0] dgnt = '0, drv = '0, derr = '0, zero3 = '0;
   logic [2:0][31:0] drdata = '0, zrdata = '0;

   logic gnt, rvalid, err, dwe;
   logic [31:0] rdata, daddr, dwdata;
   logic [3:0] dbe;
   logic [2:0] dreq;
   logic b_gnt, b_rvalid, b_err, b_dwe;
   logic [31:0] b_rdata, b_daddr, b_dwdata;
   logic [3:0] b_dbe;
   logic [2:0] b_dreq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   periph_bus_router #(.CFG(CfgA), .TIMEOUT_CYCLES(8)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr),
      .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid),
      .host_rready_i(rready), .host_rdata_o(rdata), .host_err_o(err), .dev_req_o(dreq),
      .dev_addr_o(daddr), .dev_we_o(dwe), .dev_be_o(dbe), .dev_wdata_o(dwdata),
      .dev_gnt_i(dgnt), .dev_rvalid_i(drv), .dev_rdata_i(drdata), .dev_err_i(derr));

   periph_bus_router #(.CFG(CfgB)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .host_req_i(req_b), .host_gnt_o(b_gnt), .host_addr_i(addr),
      .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(b_rvalid),
      .host_rready_i(rready), .host_rdata_o(b_rdata), .host_err_o(b_err), .dev_req_o(b_dreq),
      .dev_addr_o(b_daddr), .dev_we_o(b_dwe), .dev_be_o(b_dbe), .dev_wdata_o(b_dwdata),
      .dev_gnt_i(zero3), .dev_rvalid_i(zero3), .dev_rdata_i(zrdata), .dev_err_i(zero3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_gnt", 32'(gnt), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_dreq", 32'(dreq), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: UART read, gnt immediately, rvalid two cycles later.
      addr = 32'h1000_0004; we = 1'b0; req = 1'b1; dgnt = 3'b010;
      tick();
      req = 1'b0;
      chk("t1_dreq", 32'(dreq), 32'h2);
      chk("t1_daddr", daddr, 32'h1000_0004);
      chk("t1_gnt_busy", 32'(gnt), 32'd0);
      tick();
      dgnt = '0;
      chk("t1_dreq_wait", 32'(dreq), 32'd0);
      drv = 3'b010; drdata[1] = 32'hA5;
      tick();
      drv = '0;
      chk("t1_rvalid", 32'(rvalid), 32'd1);
      chk("t1_rdata", rdata, 32'hA5);
      chk("t1_err", 32'(err), 32'd0);
      tick();
      chk("t1_idle", 32'(gnt), 32'd1);

      // 2: misaligned write and unmapped read give an error one cycle after acceptance.
      addr = 32'h0000_1FFF; we = 1'b1; wdata = 32'h1111_2222; req = 1'b1;
      tick();
      req = 1'b0;
      chk("t2a_rvalid", 32'(rvalid), 32'd1);
      chk("t2a_err", 32'(err), 32'd1);
      chk("t2a_rdata", rdata, 32'd0);
      chk("t2a_dreq", 32'(dreq), 32'd0);
      tick();
      addr = 32'h0000_2000; we = 1'b0; req = 1'b1;
      tick();
      req = 1'b0;
      chk("t2b_rvalid", 32'(rvalid), 32'd1);
      chk("t2b_err", 32'(err), 32'd1);
      chk("t2b_dreq", 32'(dreq), 32'd0);
      tick();

      // 3: last BOOTROM word is inside the window; UART unsupported on the second instance.
      addr = 32'h0000_1FFC; req = 1'b1; dgnt = 3'b001; drv = 3'b001; drdata[0] = 32'hB00C;
      tick();
      req = 1'b0;
      chk("t3_dreq", 32'(dreq), 32'h1);
      tick();
      dgnt = '0; drv = '0;
      chk("t3_rdata", rdata, 32'hB00C);
      chk("t3_err", 32'(err), 32'd0);
      tick();
      addr = 32'h1000_0000; req_b = 1'b1;
      tick();
      req_b = 1'b0;
      chk("t3b_rvalid", 32'(b_rvalid), 32'd1);
      chk("t3b_err", 32'(b_err), 32'd1);
      chk("t3b_dreq", 32'(b_dreq), 32'd0);
      chk("t3b_a_idle", 32'(gnt), 32'd1);
      tick();

      // 4: PLIC never answers; timeout fires 8 cycles after entering DEV_REQ.
      addr = 32'h0C00_0010; req = 1'b1; dgnt = 3'b100; rready = 1'b0;
      tick();
      req = 1'b0;
      chk("t4_dreq", 32'(dreq), 32'h4);
      for (int i = 0; i < 7; i++) tick();
      dgnt = '0;
      chk("t4_not_yet", 32'(rvalid), 32'd0);
      tick();
      chk("t4_rvalid", 32'(rvalid), 32'd1);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_rdata", rdata, 32'd0);
      drv = 3'b100; drdata[2] = 32'hDEAD_BEEF;
      tick();
      drv = '0;
      chk("t4_late_rdata", rdata, 32'd0);
      chk("t4_late_err", 32'(err), 32'd1);
      rready = 1'b1;
      tick();
      chk("t4_idle", 32'(gnt), 32'd1);

      // 5: back-pressure in RESP, write fields on the shared bus, then reset in DEV_WAIT.
      addr = 32'h1000_0000; we = 1'b1; be = 4'h3; wdata = 32'hCAFE_F00D; req = 1'b1;
      dgnt = 3'b010; drv = 3'b010; drdata[1] = 32'h5A5A; rready = 1'b0;
      tick();
      req = 1'b0;
      chk("t5_dwe", 32'(dwe), 32'd1);
      chk("t5_dbe", 32'(dbe), 32'h3);
      chk("t5_dwdata", dwdata, 32'hCAFE_F00D);
      tick();
      dgnt = '0; drv = '0;
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_rvalid", 32'(rvalid), 32'd1);
         chk("t5_hold_rdata", rdata, 32'h5A5A);
         chk("t5_hold_gnt", 32'(gnt), 32'd0);
         tick();
      end
      rready = 1'b1; we = 1'b0; be = 4'hF;
      tick();
      chk("t5_idle", 32'(gnt), 32'd1);
      addr = 32'h0C00_0000; req = 1'b1; dgnt = 3'b100;
      tick();
      req = 1'b0;
      tick();
      dgnt = '0;
      chk("t5_wait_daddr", daddr, 32'h0C00_0000);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_daddr", daddr, 32'd0);
      chk("t5_rst_gnt", 32'(gnt), 32'd1);
      chk("t5_rst_rvalid", 32'(rvalid), 32'd0);
      tick();
      rst_n = 1'b1;
      drv = 3'b100;
      tick();
      drv = '0;
      tick();
      chk("t5_no_resp", 32'(rvalid), 32'd0);

      // 6: BOOTROM gnt+rvalid together with a stray UART response.
      addr = 32'h0000_1000; req = 1'b1; dgnt = 3'b001; drv = 3'b011; derr = 3'b010;
      drdata[0] = 32'h1234_5678; drdata[1] = 32'h0000_0BAD;
      tick();
      req = 1'b0;
      chk("t6_dreq", 32'(dreq), 32'h1);
      tick();
      dgnt = '0; drv = '0; derr = '0;
      chk("t6_rvalid", 32'(rvalid), 32'd1);
      chk("t6_rdata", rdata, 32'h1234_5678);
      chk("t6_err", 32'(err), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

endmodule
